// File: rtl/ofs_fim_if_pkg.sv
// ---------------------------------------------------------------------------
// ofs_fim_if_pkg
// Shared definitions for the AFU interrupt response path:
//   - rsp_state_e   : response FSM state (IDLE / SEND)
//   - RSP_* consts  : tdata field widths and bit offsets
//   - rsp_tdata_t   : packed response word (coalesced flag, reserved, index)
//   - make_rsp()    : builds a response word with the reserved field zeroed
// ---------------------------------------------------------------------------
package ofs_fim_if_pkg;

  // Response FSM states. The encoding matches the legacy constants
  // (IDLE = 0, SEND = 1), so rsp_tvalid is simply "state == SEND".
  typedef enum logic [0:0] {
    RSP_IDLE = 1'b0,
    RSP_SEND = 1'b1
  } rsp_state_e;

  // tdata layout: [5:0] vector index, [22:6] zero, [23] coalesced flag
  localparam int RSP_TDATA_W  = 24;
  localparam int RSP_IDX_LSB  = 0;
  localparam int RSP_IDX_W    = 6;
  localparam int RSP_RSVD_LSB = 6;
  localparam int RSP_RSVD_W   = 17;
  localparam int RSP_COAL_BIT = 23;

  typedef struct packed {
    logic                  coal;   // bit 23
    logic [RSP_RSVD_W-1:0] rsvd;   // bits 22:6, always zero
    logic [RSP_IDX_W-1:0]  idx;    // bits 5:0
  } rsp_tdata_t;

  function automatic rsp_tdata_t make_rsp(input logic [RSP_IDX_W-1:0] idx,
                                          input logic                 coal);
    rsp_tdata_t r;
    r.coal = coal;
    r.rsvd = '0;
    r.idx  = idx;
    return r;
  endfunction

endpackage : ofs_fim_if_pkg

// File: rtl/ofs_fim_rr_arb.sv
// ---------------------------------------------------------------------------
// ofs_fim_rr_arb
// Purely combinational round-robin picker. The search starts at 'ptr' and
// walks upward (wrapping at N) until the first set request bit is found.
// Ports:
//   req  [N-1:0]  in   request vector (already qualified by the caller)
//   ptr  [IW-1:0] in   search start position, must be < N
//   gnt  [N-1:0]  out  one-hot grant (all zero when nothing requested)
//   idx  [IW-1:0] out  binary index of the granted bit
//   any           out  at least one request present
// ---------------------------------------------------------------------------
module ofs_fim_rr_arb #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0]   pos_sum;
  logic [IW-1:0] pos;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    any     = 1'b0;
    pos_sum = '0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      // ptr + k wraps modulo N; one extra bit keeps the sum exact
      // because both operands are below N.
      pos_sum = {1'b0, ptr} + (IW+1)'(k);
      if (pos_sum >= (IW+1)'(N)) begin
        pos_sum = pos_sum - (IW+1)'(N);
      end
      pos = pos_sum[IW-1:0];
      if (!any && req[pos]) begin
        any      = 1'b1;
        idx      = pos;
        gnt[pos] = 1'b1;
      end
    end
  end

endmodule : ofs_fim_rr_arb

// File: rtl/ofs_fim_irq_rsp_arb.sv
// ---------------------------------------------------------------------------
// ofs_fim_irq_rsp_arb
// Collects per-vector AFU interrupt request pulses into pending bits and
// emits one response beat per granted vector on an AXI-stream style output,
// picking among unmasked pending vectors in round-robin order. A request
// that arrives while its vector is already pending is coalesced: the
// coalesced flag rides along in tdata[23] of that vector's next response.
//
// Optional feature macro: OFS_FIM_IRQ_RSP_ARB_STATS_EN
//   defined   -> coalesce_cnt is a 16-bit saturating count of coalesce events
//   undefined -> coalesce_cnt is tied to zero (coal flags still operate)
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset
//   irq_req       in   [NUM_VEC] single-cycle request pulses
//   irq_mask      in   [NUM_VEC] 1 = vector may not be granted (still captured)
//   rsp_tvalid    out  response valid
//   rsp_tready    in   response ready
//   rsp_tdata     out  [TDATA_WIDTH] {coal, 17'b0, index[5:0]}
//   pending       out  [NUM_VEC] pending bits
//   coalesce_cnt  out  [16] saturating coalesce counter
// ---------------------------------------------------------------------------
module ofs_fim_irq_rsp_arb
  import ofs_fim_if_pkg::*;
#(
  parameter int NUM_VEC     = 4,
  parameter int TDATA_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_VEC-1:0]     irq_req,
  input  logic [NUM_VEC-1:0]     irq_mask,
  output logic                   rsp_tvalid,
  input  logic                   rsp_tready,
  output logic [TDATA_WIDTH-1:0] rsp_tdata,
  output logic [NUM_VEC-1:0]     pending,
  output logic [15:0]            coalesce_cnt
);

  localparam int IW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;

  if (TDATA_WIDTH != RSP_TDATA_W) begin : g_bad_tdata_width
    $error("ofs_fim_irq_rsp_arb: TDATA_WIDTH must be 24");
  end
  if (NUM_VEC < 1 || NUM_VEC > 64) begin : g_bad_num_vec
    $error("ofs_fim_irq_rsp_arb: NUM_VEC must be in 1..64");
  end

  rsp_state_e         state_q, state_d;
  rsp_tdata_t         tdata_q, tdata_d;
  logic [NUM_VEC-1:0] pending_q, pending_d;
  logic [NUM_VEC-1:0] coal_q, coal_d;
  logic [IW-1:0]      ptr_q, ptr_d;

  logic [NUM_VEC-1:0] eligible;
  logic [NUM_VEC-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;
  logic [NUM_VEC-1:0] clr;        // pending/coal bits cleared by this cycle's grant
  logic [NUM_VEC-1:0] coal_evt;   // requests that land on a still-pending vector

  assign eligible = pending_q & ~irq_mask;

  ofs_fim_rr_arb #(
    .N  (NUM_VEC),
    .IW (IW)
  ) u_rr_arb (
    .req (eligible),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    state_d = state_q;
    tdata_d = tdata_q;
    ptr_d   = ptr_q;
    clr     = '0;

    // A new beat may be loaded when the output slot is empty or is being
    // accepted this cycle; otherwise the in-flight beat is frozen, which
    // also keeps it immune to mask changes.
    if (state_q == RSP_IDLE || rsp_tready) begin
      if (arb_any) begin
        state_d = RSP_SEND;
        tdata_d = make_rsp(RSP_IDX_W'(arb_idx), |(coal_q & arb_gnt));
        clr     = arb_gnt;
        ptr_d   = (arb_idx == IW'(NUM_VEC - 1)) ? '0 : arb_idx + IW'(1);
      end else begin
        state_d = RSP_IDLE;
      end
    end

    // Set wins over clear: a request in the grant cycle re-arms the vector
    // as a fresh (non-coalesced) pending interrupt.
    coal_evt  = irq_req & pending_q & ~clr;
    pending_d = (pending_q & ~clr) | irq_req;
    coal_d    = (coal_q & ~clr) | coal_evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RSP_IDLE;
      tdata_q   <= '0;
      pending_q <= '0;
      coal_q    <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      tdata_q   <= tdata_d;
      pending_q <= pending_d;
      coal_q    <= coal_d;
      ptr_q     <= ptr_d;
    end
  end

`ifdef OFS_FIM_IRQ_RSP_ARB_STATS_EN
  logic [15:0] cnt_q, cnt_d;
  logic [6:0]  evt_num;
  logic [16:0] cnt_sum;

  // Several vectors can coalesce in the same cycle; each one counts.
  always_comb begin
    evt_num = '0;
    for (int i = 0; i < NUM_VEC; i++) begin
      evt_num = evt_num + 7'(coal_evt[i]);
    end
    cnt_sum = {1'b0, cnt_q} + 17'(evt_num);
    cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign coalesce_cnt = cnt_q;
`else
  assign coalesce_cnt = '0;
`endif

  assign rsp_tvalid = (state_q == RSP_SEND);
  assign rsp_tdata  = tdata_q;
  assign pending    = pending_q;

endmodule : ofs_fim_irq_rsp_arb

// File: tb/tb_ofs_fim_irq_rsp_arb.sv
// ---------------------------------------------------------------------------
// tb_ofs_fim_irq_rsp_arb
// Directed scenarios followed by randomized traffic. A reference model
// tracks pending/coalesced sets, the round-robin start point and the
// saturating counter; every beat it predicts is queued and a separate
// monitor pops and compares on each accepted beat.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ofs_fim_irq_rsp_arb;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_req;
  logic [N-1:0]  irq_mask;
  logic          rsp_tvalid;
  logic          rsp_tready;
  logic [23:0]   rsp_tdata;
  logic [N-1:0]  pending;
  logic [15:0]   coalesce_cnt;

  always #5 clk = ~clk;

  ofs_fim_irq_rsp_arb #(
    .NUM_VEC     (N),
    .TDATA_WIDTH (24)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .irq_req      (irq_req),
    .irq_mask     (irq_mask),
    .rsp_tvalid   (rsp_tvalid),
    .rsp_tready   (rsp_tready),
    .rsp_tdata    (rsp_tdata),
    .pending      (pending),
    .coalesce_cnt (coalesce_cnt)
  );

`ifdef OFS_FIM_IRQ_RSP_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit [N-1:0]  m_pend;
  bit [N-1:0]  m_coal;
  bit          m_busy;
  logic [23:0] m_cur;
  int          m_ptr;
  int          m_cnt;
  logic [23:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock with the given inputs.
  task automatic model_next(input logic [N-1:0] req, input logic [N-1:0] mask,
                            input logic rdy, input logic r);
    int w;
    if (r) begin
      m_pend = '0; m_coal = '0; m_busy = 1'b0; m_cur = '0; m_ptr = 0; m_cnt = 0;
      exp_q.delete();
      return;
    end
    w = -1;
    if (!m_busy || rdy) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (w < 0 && m_pend[c] && !mask[c]) w = c;
      end
      if (w >= 0) begin
        m_cur     = 24'(w);
        m_cur[23] = m_coal[w];
        exp_q.push_back(m_cur);
        m_busy    = 1'b1;
        m_ptr     = (w + 1) % N;
        m_pend[w] = 1'b0;
        m_coal[w] = 1'b0;
      end else begin
        m_busy = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        if (m_pend[i]) begin
          m_coal[i] = 1'b1;
          if (STATS && m_cnt < 65535) m_cnt++;
        end
        m_pend[i] = 1'b1;
      end
    end
  endtask

  // Apply inputs for one cycle, then compare outputs just after the edge.
  task automatic step(input logic [N-1:0] req, input logic [N-1:0] mask,
                      input logic rdy, input logic r);
    irq_req    = req;
    irq_mask   = mask;
    rsp_tready = rdy;
    rst        = r;
    model_next(req, mask, rdy, r);
    @(posedge clk);
    #1;
    check("tvalid",  32'(rsp_tvalid),   32'(m_busy));
    check("pending", 32'(pending),      32'(m_pend));
    check("coal_cnt", 32'(coalesce_cnt), 32'(m_cnt));
    if (m_busy) check("tdata", 32'(rsp_tdata), 32'(m_cur));
  endtask

  // Monitor: every accepted beat must match the oldest predicted beat.
  always @(negedge clk) begin
    if (rst === 1'b0 && rsp_tvalid === 1'b1 && rsp_tready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("beat_unexpected", 32'(rsp_tdata), 32'hFFFF_FFFF);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        check("beat", 32'(rsp_tdata), 32'(e));
        $display("beat idx=%0d coal=%0b exp_idx=%0d t=%0t",
                 rsp_tdata[5:0], rsp_tdata[23], e[5:0], $time);
      end
    end
  end

  initial begin
    logic [N-1:0] rq, mk;
    logic         rd, rs;

    // Reset state
    step('0, '0, 1'b1, 1'b1);
    step('0, '0, 1'b1, 1'b1);
    check("rst_tvalid", 32'(rsp_tvalid), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_cnt", 32'(coalesce_cnt), 32'd0);

    // Single request, two-cycle latency
    step(4'b0100, '0, 1'b1, 1'b0);
    check("lat_pending", 32'(pending), 32'h4);
    step('0, '0, 1'b1, 1'b0);
    check("lat_tvalid", 32'(rsp_tvalid), 32'd1);
    check("lat_tdata", 32'(rsp_tdata), 32'h000002);
    step('0, '0, 1'b1, 1'b0);
    check("lat_pend_clr", 32'(pending), 32'd0);
    check("lat_idle", 32'(rsp_tvalid), 32'd0);

    // All four at once: back-to-back beats 0,1,2,3
    step('0, '0, 1'b1, 1'b1);
    step(4'b1111, '0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step('0, '0, 1'b1, 1'b0);
      check("b2b_tvalid", 32'(rsp_tvalid), 32'd1);
      check("b2b_idx", 32'(rsp_tdata[5:0]), 32'(k));
    end
    step('0, '0, 1'b1, 1'b0);
    check("b2b_end", 32'(rsp_tvalid), 32'd0);

    // Coalescing while masked, then held with tready low
    step('0, '0, 1'b1, 1'b1);
    step(4'b0010, 4'b0010, 1'b0, 1'b0);
    step(4'b0010, 4'b0010, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("coal_tdata", 32'(rsp_tdata), 32'h800001);
      check("coal_cnt_d", 32'(coalesce_cnt), STATS ? 32'd1 : 32'd0);
      step('0, '0, 1'b0, 1'b0);
    end
    step('0, '0, 1'b1, 1'b0);

    // Mask steers grant to vector 1, then vector 0 after unmask
    step('0, '0, 1'b1, 1'b1);
    step(4'b0011, 4'b0001, 1'b1, 1'b0);
    step('0, 4'b0001, 1'b1, 1'b0);
    check("mask_first", 32'(rsp_tdata), 32'h000001);
    step('0, '0, 1'b1, 1'b0);
    check("mask_second", 32'(rsp_tdata), 32'h000000);
    check("mask_second_v", 32'(rsp_tvalid), 32'd1);
    step('0, '0, 1'b1, 1'b0);

    // Reset mid-SEND discards the beat and ignores requests
    step(4'b0100, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    step(4'b0001, '0, 1'b0, 1'b0);
    step(4'b0010, '0, 1'b0, 1'b1);
    check("midrst_tvalid", 32'(rsp_tvalid), 32'd0);
    check("midrst_pending", 32'(pending), 32'd0);
    check("midrst_cnt", 32'(coalesce_cnt), 32'd0);
    step(4'b1001, '0, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    check("midrst_first", 32'(rsp_tdata[5:0]), 32'd0);
    step('0, '0, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rq = '0;
      for (int i = 0; i < N; i++) rq[i] = ($urandom_range(0, 3) == 0);
      mk = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      rd = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 199) == 0);
      step(rq, mk, rd, rs);
    end

    // Counter saturation: four coalesce events per cycle, well past 65535
    step('0, '0, 1'b1, 1'b1);
    for (int c = 0; c < 17600; c++) begin
      step(4'b1111, 4'b1111, 1'b1, 1'b0);
    end
    check("sat_cnt", 32'(coalesce_cnt), STATS ? 32'h0000FFFF : 32'd0);
    step('0, '0, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ofs_fim_irq_rsp_arb
